// File: rtl/segment_sequencer.sv
// Sequences one train pass over sensors S1..S6, timing each segment in ticks and
// raising an alarm on a predicted-timeout or an out-of-order sensor edge.
module segment_sequencer #(
   parameter int unsigned TW           = 19,
   parameter int unsigned T_DEFAULT    = 500000,
   parameter int unsigned MARGIN_SHIFT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [5:0]    sens,
   input  logic          tick,
   input  logic          clr,
   output logic [3:0]    state,
   output logic          seg_pulse,
   output logic [TW-1:0] last_time,
   output logic [TW-1:0] limit,
   output logic          alarm,
   output logic          done
);

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StSeg1  = 4'd1,
      StSeg2  = 4'd2,
      StSeg3  = 4'd3,
      StSeg4  = 4'd4,
      StSeg5  = 4'd5,
      StDone  = 4'd6,
      StAlarm = 4'd15
   } state_e;

   localparam logic [TW-1:0] CountMax  = {TW{1'b1}};
   localparam logic [TW-1:0] LimitInit = TW'(T_DEFAULT);

   state_e        state_q, state_d;
   logic [TW-1:0] count_q, count_d;
   logic [TW-1:0] last_time_q, last_time_d;
   logic [TW-1:0] limit_q, limit_d;
   logic          pulse_q, pulse_d;
   logic [5:0]    sens_q;

   logic [5:0]    rise;
   logic [5:0]    expected;
   logic [TW:0]   margin_sum;
   logic [TW-1:0] next_limit;

   assign rise = sens & ~sens_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         last_time_q <= '0;
         limit_q     <= LimitInit;
         pulse_q     <= 1'b0;
         sens_q      <= 6'b111111;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         last_time_q <= last_time_d;
         limit_q     <= limit_d;
         pulse_q     <= pulse_d;
         sens_q      <= sens;
      end
   end

   // Next limit is the measured time plus a margin, saturated and never zero.
   always_comb begin
      expected   = 6'b000001 << state_q;
      margin_sum = {1'b0, count_q} + {1'b0, count_q >> MARGIN_SHIFT};
      next_limit = margin_sum[TW] ? CountMax : margin_sum[TW-1:0];
      if (next_limit == '0) next_limit = TW'(1);
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      last_time_d = last_time_q;
      limit_d     = limit_q;
      pulse_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (rise[0]) begin
               state_d = StSeg1;
               count_d = '0;
               limit_d = LimitInit;
               pulse_d = 1'b1;
            end
         end
         StSeg1, StSeg2, StSeg3, StSeg4, StSeg5: begin
            // An accepted edge takes priority over a timeout in the same cycle.
            if (rise == expected) begin
               last_time_d = count_q;
               limit_d     = next_limit;
               count_d     = '0;
               pulse_d     = 1'b1;
               state_d     = (state_q == StSeg5) ? StDone : state_e'(state_q + 4'd1);
            end else if (rise != 6'b0) begin
               state_d = StAlarm;
            end else if (tick) begin
               if (count_q == limit_q) state_d = StAlarm;
               else if (count_q != CountMax) count_d = count_q + TW'(1);
            end
         end
         StAlarm: begin
            if (clr) begin
               state_d = StIdle;
               count_d = '0;
            end
         end
         StDone: begin
            if (clr) begin
               state_d = StIdle;
               count_d = '0;
            end else if (rise[0]) begin
               state_d = StSeg1;
               count_d = '0;
               limit_d = LimitInit;
               pulse_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      state     = state_q;
      seg_pulse = pulse_q;
      last_time = last_time_q;
      limit     = limit_q;
      alarm     = (state_q == StAlarm);
      done      = (state_q == StDone);
   end

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer: expected outputs are queued when stimulus
// is driven and popped for comparison one cycle later.
module tb_segment_sequencer;

   localparam int unsigned TW = 19;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [5:0]    sens;
   logic          tick;
   logic          clr;
   logic [3:0]    state;
   logic          seg_pulse;
   logic [TW-1:0] last_time;
   logic [TW-1:0] limit;
   logic          alarm;
   logic          done;

   typedef struct {
      logic [3:0]    st;
      logic [TW-1:0] lt;
      logic [TW-1:0] lim;
      logic          al;
      logic          dn;
      logic          sp;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    checks = 0;
   int    errors = 0;
   int    pulses = 0;
   int    p0;

   segment_sequencer #(
      .TW          (TW),
      .T_DEFAULT   (20),
      .MARGIN_SHIFT(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sens     (sens),
      .tick     (tick),
      .clr      (clr),
      .state    (state),
      .seg_pulse(seg_pulse),
      .last_time(last_time),
      .limit    (limit),
      .alarm    (alarm),
      .done     (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (seg_pulse === 1'b1) pulses++;

   task automatic cmp(input string tag, input string field, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
      end
   endtask

   task automatic observe();
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = tags.pop_front();
      cmp(t, "state", 32'(state), 32'(e.st));
      cmp(t, "last_time", 32'(last_time), 32'(e.lt));
      cmp(t, "limit", 32'(limit), 32'(e.lim));
      cmp(t, "alarm", 32'(alarm), 32'(e.al));
      cmp(t, "done", 32'(done), 32'(e.dn));
      cmp(t, "seg_pulse", 32'(seg_pulse), 32'(e.sp));
   endtask

   // Queue the expected outputs, let one rising edge happen, then compare.
   task automatic expect_step(input string tag, input logic [3:0] st, input int lt,
                              input int lim, input logic sp);
      exp_t e;
      e.st  = st;
      e.lt  = TW'(lt);
      e.lim = TW'(lim);
      e.al  = (st == 4'd15);
      e.dn  = (st == 4'd6);
      e.sp  = sp;
      sb.push_back(e);
      tags.push_back(tag);
      @(negedge clk);
      observe();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      sens  = 6'b000001;
      tick  = 1'b1;
      clr   = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;

      // Reset with S1 held high: no start.
      expect_step("reset", 4'd0, 0, 20, 1'b0);
      wait_cycles(3);
      expect_step("held_s1", 4'd0, 0, 20, 1'b0);
      sens = 6'b000000;
      wait_cycles(1);

      // Nominal pass, 16 ticks per segment.
      p0 = pulses;
      sens = 6'b000001;
      expect_step("start", 4'd1, 0, 20, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         wait_cycles(16);
         sens[k] = 1'b1;
         expect_step($sformatf("seg%0d", k + 1), (k == 5) ? 4'd6 : 4'(k + 1), 16, 20, 1'b1);
      end
      expect_step("done_hold", 4'd6, 16, 20, 1'b0);
      cmp("nominal", "pulse_count", 32'(pulses - p0), 32'd6);

      // Timeout after S2.
      clr = 1'b1;
      sens = 6'b000000;
      expect_step("clr_done", 4'd0, 16, 20, 1'b0);
      clr = 1'b0;
      sens = 6'b000001;
      expect_step("to_s1", 4'd1, 16, 20, 1'b1);
      wait_cycles(16);
      sens = 6'b000011;
      expect_step("to_s2", 4'd2, 16, 20, 1'b1);
      wait_cycles(19);
      expect_step("pre_timeout", 4'd2, 16, 20, 1'b0);
      expect_step("timeout", 4'd15, 16, 20, 1'b0);
      sens = 6'b111111;
      expect_step("alarm_ignores_edges", 4'd15, 16, 20, 1'b0);
      clr = 1'b1;
      sens = 6'b000000;
      expect_step("clr_alarm", 4'd0, 16, 20, 1'b0);
      clr = 1'b0;

      // Out-of-order S4 in state 2.
      sens = 6'b000001;
      expect_step("ooo_s1", 4'd1, 16, 20, 1'b1);
      wait_cycles(16);
      sens = 6'b000011;
      expect_step("ooo_s2", 4'd2, 16, 20, 1'b1);
      sens = 6'b001011;
      expect_step("ooo_s4", 4'd15, 16, 20, 1'b0);
      clr = 1'b1;
      sens = 6'b000000;
      expect_step("ooo_clr", 4'd0, 16, 20, 1'b0);
      clr = 1'b0;

      // S3 and S5 together in state 2.
      sens = 6'b000001;
      expect_step("dual_s1", 4'd1, 16, 20, 1'b1);
      wait_cycles(16);
      sens = 6'b000011;
      expect_step("dual_s2", 4'd2, 16, 20, 1'b1);
      sens = 6'b010111;
      expect_step("dual_s3_s5", 4'd15, 16, 20, 1'b0);
      clr = 1'b1;
      sens = 6'b000000;
      expect_step("dual_clr", 4'd0, 16, 20, 1'b0);
      clr = 1'b0;

      // Expected edge on the same tick as count==limit: edge wins.
      sens = 6'b000001;
      expect_step("sim_s1", 4'd1, 16, 20, 1'b1);
      wait_cycles(16);
      sens = 6'b000011;
      expect_step("sim_s2", 4'd2, 16, 20, 1'b1);
      wait_cycles(20);
      sens = 6'b000111;
      expect_step("sim_s3", 4'd3, 20, 25, 1'b1);

      // Reset mid-run, then S1 must fall and rise again to start.
      rst_n = 1'b0;
      expect_step("mid_reset", 4'd0, 0, 20, 1'b0);
      rst_n = 1'b1;
      expect_step("post_reset_held", 4'd0, 0, 20, 1'b0);
      sens = 6'b000000;
      wait_cycles(1);
      sens = 6'b000001;
      expect_step("restart_s1", 4'd1, 0, 20, 1'b1);
      wait_cycles(16);
      sens = 6'b000011;
      expect_step("restart_s2", 4'd2, 16, 20, 1'b1);
      clr = 1'b1;
      expect_step("clr_in_run", 4'd2, 16, 20, 1'b0);
      clr = 1'b0;

      cmp("scoreboard", "leftover", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
- Sequences one train pass across the six track sensors S1..S6.
- Detects sensor rising edges in the expected order and measures the time of each segment in ticks.
- Predicts a timeout for the next segment from the last measurement and raises an alarm on timeout or an out-of-order sensor.
- Sits between the synchronizer outputs and the display/timer logic; drives the 4-bit present state consumed by the display.

Parameters:
- TW, 19, width of the time counter, measured time and limit.
- T_DEFAULT, 500000, timeout limit for the first segment (S1->S2).
- MARGIN_SHIFT, 2, timeout margin: limit = m + (m >> MARGIN_SHIFT).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Reset is synchronous and active-low; one clock `clk`, with all state updating on its rising edge.
- sens  in  6  synchronized sensor levels; bit0=S1 ... bit5=S6.
- tick  in  1  one-cycle time-base enable.
- clr  in  1  clears ALARM/DONE back to IDLE.
- state  out  4  0=IDLE, 1..5=sensors passed, 6=DONE, 15=ALARM.
- seg_pulse  out  1  one-cycle pulse when the expected sensor is passed.
- last_time  out  TW  measured ticks of the last completed segment.
- limit  out  TW  active timeout limit.
- alarm  out  1  high while in ALARM.
- done  out  1  high while in DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=0, count=0, last_time=0, limit=T_DEFAULT, seg_pulse=0, alarm=0, done=0.
  - sens_q loads 6'b111111, so a sensor held high through reset gives no edge.
  - Reset mid-run aborts immediately.
- Edge detect: rise = sens & ~sens_q; sens_q <= sens every cycle. Response updates at the same clk edge that samples the rise; visible the next cycle.
- IDLE:
  - rise[0] -> state=1, count=0, limit=T_DEFAULT, seg_pulse=1.
  - Any other edge is ignored.
- RUN (state k, k=1..5, expected edge = rise[k]):
  - count increments on tick and saturates at 2^TW-1.
  - Expected edge alone:
    - last_time=count (value before this edge);
    - limit=max(1, sat(count + (count>>MARGIN_SHIFT)));
    - count=0 (a tick in the same cycle is ignored);
    - seg_pulse=1;
    - state=k+1. k=5 goes to DONE (state=6, done=1).
  - Any unexpected edge (including rise[0] or a second bit alongside the expected one) -> ALARM.
  - Timeout: tick with count==limit and no edge -> ALARM.
  - Expected edge and timeout in the same cycle -> the edge wins; advance, no alarm.
- ALARM:
  - state=15, alarm=1; count frozen, last_time/limit held.
  - Sensor edges are ignored.
  - clr -> IDLE (count=0, alarm=0).
- DONE:
  - state=6, done=1.
  - clr -> IDLE.
  - rise[0] without clr -> directly to state=1 (new pass, done=0).
- clr in IDLE or RUN has no effect.
- seg_pulse is high for exactly one cycle per accepted edge, including the IDLE->1 start; it is 0 otherwise.

Test Plan:
All scenarios use TW=19, T_DEFAULT=20, MARGIN_SHIFT=2, tick=1 every cycle.
1. Reset with sens=6'b000001 held -> state=0, last_time=0, limit=20, alarm=0; no transition while sens is held high.
2. Nominal pass: S1 rise, then S2..S6 each rising 16 ticks after the previous one.
   - After S2: last_time=16, limit=20, state=2.
   - After S6: state=6, done=1.
   - seg_pulse seen 6 times.
3. Timeout: S1, S2 at 16 (limit=20), no S3 -> alarm on the 21st tick after S2 (state=15, alarm=1); clr -> state=0, alarm=0.
4. Out-of-order: in state=2, S4 rises -> state=15 next cycle. Separately, S3 and S5 rising in the same cycle -> state=15.
5. Simultaneous: in state=2 with count==limit=20, S3 rises on the same tick -> state=3, last_time=20, limit=25, alarm=0.
6. Reset mid-run: rst_n=0 for one cycle in state=3 -> state=0, count=0, limit=20. S1 held high after reset gives no start; S1 falling then rising -> state=1.
